// File: rtl/dp_controller_pkg.sv
// dp_controller_pkg: shared states, ALU/opcode/condition encodings and helpers
package dp_controller_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, WB, SKIP} state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;
  localparam int N_BIT = 31;
  localparam int Z_BIT = 30;
  localparam int C_BIT = 29;
  localparam int V_BIT = 28;

  function automatic logic is_legal(logic [3:0] op);
    return op inside {OP_AND, OP_EOR, OP_SUB, OP_ADD, OP_CMP, OP_ORR, OP_MOV};
  endfunction

  function automatic logic [2:0] alu_of(logic [3:0] op);
    return op == OP_AND ? ALU_AND : op == OP_EOR ? ALU_EOR :
           (op == OP_SUB || op == OP_CMP) ? ALU_SUB : op == OP_ORR ? ALU_ORR : ALU_ADD;
  endfunction

  function automatic logic [31:0] ror_imm(logic [7:0] imm, logic [3:0] rot);
    logic [31:0] x;
    x = {24'h0, imm};
    return (x >> {rot, 1'b0}) | (x << (6'd32 - {1'b0, rot, 1'b0}));
  endfunction
endpackage

// File: rtl/dp_controller_if.sv
// dp_controller_if: instruction handshake, flags and datapath control bundle
interface dp_controller_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] status_out;
  logic [3:0]  A_addr;
  logic [3:0]  B_addr;
  logic [3:0]  shift_addr;
  logic        en_A;
  logic        en_B;
  logic        en_S;
  logic        en_status;
  logic [1:0]  shift_op;
  logic [31:0] shift_imme;
  logic        sel_shift;
  logic        sel_A;
  logic        sel_B;
  logic [31:0] imme_data;
  logic [2:0]  ALU_op;
  logic        w_en;
  logic [3:0]  w_addr;
  logic        done;
  logic        illegal;
  modport master (
    output instr, instr_valid, status_out,
    input  instr_ready, A_addr, B_addr, shift_addr, en_A, en_B, en_S, en_status, shift_op,
           shift_imme, sel_shift, sel_A, sel_B, imme_data, ALU_op, w_en, w_addr, done, illegal
  );
  modport slave (
    input  instr, instr_valid, status_out,
    output instr_ready, A_addr, B_addr, shift_addr, en_A, en_B, en_S, en_status, shift_op,
           shift_imme, sel_shift, sel_A, sel_B, imme_data, ALU_op, w_en, w_addr, done, illegal
  );
endinterface

// File: rtl/dp_controller_cond_check.sv
// cond_check: ARM condition-field evaluation against NZCV flags
module cond_check
  import dp_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  // decode the condition code; NV never passes
  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = n == v;
      CC_LT: pass = n != v;
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/dp_controller.sv
// dp_controller: sequences one ARM data-processing instruction through LOAD/EXEC/WB
module dp_controller
  import dp_controller_pkg::*;
(
  input logic            clk,
  input logic            rst,
  dp_controller_if.slave bus
);
  state_t      st;
  logic [25:0] ir;
  logic        ill, pass, legal, acc, ld, ex, opnd, imm_f, reg_f;
  logic [3:0]  op;
  cond_check u_cond (
    .cond  (bus.instr[31:28]),
    .flags ({bus.status_out[N_BIT], bus.status_out[Z_BIT], bus.status_out[C_BIT], bus.status_out[V_BIT]}),
    .pass  (pass)
  );
  assign legal = is_legal(bus.instr[24:21]);
  assign acc = bus.instr_valid && bus.instr_ready;
  // latch on accept, branch to SKIP on failed condition or undefined opcode, else walk the pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      ir  <= '0;
      ill <= 1'b0;
    end else if (acc) begin
      ir  <= bus.instr[25:0];
      ill <= !legal;
      st  <= pass && legal ? LOAD : SKIP;
    end else
      st <= st == LOAD ? EXEC : st == EXEC ? WB : IDLE;
  end
  assign op    = ir[24:21];
  assign imm_f = ir[25];
  assign reg_f = !ir[25];
  assign ld    = !rst && st == LOAD;
  assign ex    = !rst && st == EXEC;
  assign opnd  = ld || ex;
  assign bus.instr_ready = st == IDLE;
  assign bus.A_addr      = ld ? ir[19:16] : 4'h0;
  assign bus.B_addr      = ld ? ir[3:0] : 4'h0;
  assign bus.shift_addr  = ld ? ir[11:8] : 4'h0;
  assign bus.en_A        = ld;
  assign bus.en_B        = ld;
  assign bus.en_S        = ld;
  assign bus.sel_B       = opnd && imm_f;
  assign bus.imme_data   = opnd && imm_f ? ror_imm(ir[7:0], ir[11:8]) : 32'h0;
  assign bus.shift_op    = opnd && reg_f ? ir[6:5] : 2'b00;
  assign bus.sel_shift   = opnd && reg_f && ir[4];
  assign bus.shift_imme  = opnd && reg_f && !ir[4] ? {27'h0, ir[11:7]} : 32'h0;
  assign bus.sel_A       = opnd && op == OP_MOV;
  assign bus.ALU_op      = ex ? alu_of(op) : 3'b000;
  assign bus.en_status   = ex && (ir[20] || op == OP_CMP);
  assign bus.w_en        = !rst && st == WB && op != OP_CMP;
  assign bus.w_addr      = bus.w_en ? ir[15:12] : 4'h0;
  assign bus.done        = !rst && (st == WB || st == SKIP);
  assign bus.illegal     = !rst && st == SKIP && ill;
endmodule

// File: tb/tb_dp_controller.sv
// tb_dp_controller: scoreboard bench for the data-processing controller
module tb_dp_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  dp_controller_if bus ();
  dp_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic        skip, ill;
    logic [3:0]  a, b, s;
    logic        selb, sela;
    logic [31:0] imm;
    logic [1:0]  sop;
    logic        ssel;
    logic [31:0] simm;
    logic [2:0]  alu;
    logic        ens, wen;
    logic [3:0]  wa;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [94:0] outs;
  assign outs = {bus.A_addr, bus.B_addr, bus.shift_addr, bus.en_A, bus.en_B, bus.en_S, bus.en_status,
                 bus.shift_op, bus.shift_imme, bus.sel_shift, bus.sel_A, bus.sel_B, bus.imme_data,
                 bus.ALU_op, bus.w_en, bus.w_addr, bus.done, bus.illegal};

  function automatic logic cond_ok(logic [3:0] c, logic [31:0] st);
    logic n, z, cf, v;
    n = st[31]; z = st[30]; cf = st[29]; v = st[28];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf & !z;
      4'h9: return !cf | z;
      4'hA: return !(n ^ v);
      4'hB: return n ^ v;
      4'hC: return !z & !(n ^ v);
      4'hD: return z | (n ^ v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(logic [31:0] i, logic [31:0] st);
    exp_t e;
    logic [3:0] op;
    logic leg;
    logic [31:0] v;
    int n;
    e = '{default: '0};
    op = i[24:21];
    leg = op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'hA, 4'hC, 4'hD};
    e.ill = !leg;
    e.skip = !leg || !cond_ok(i[31:28], st);
    if (!e.skip) begin
      e.a = i[19:16]; e.b = i[3:0]; e.s = i[11:8];
      if (i[25]) begin
        v = {24'h0, i[7:0]};
        n = 2 * int'(i[11:8]);
        for (int r = 0; r < n; r++) v = {v[0], v[31:1]};
        e.selb = 1'b1; e.imm = v;
      end else begin
        e.sop = i[6:5]; e.ssel = i[4];
        e.simm = i[4] ? 32'h0 : {27'h0, i[11:7]};
      end
      e.sela = op == 4'hD;
      case (op)
        4'h0: e.alu = 3'b010;
        4'h1: e.alu = 3'b100;
        4'h2, 4'hA: e.alu = 3'b001;
        4'hC: e.alu = 3'b011;
        default: e.alu = 3'b000;
      endcase
      e.ens = i[20] || op == 4'hA;
      e.wen = op != 4'hA;
      e.wa = e.wen ? i[15:12] : 4'h0;
    end
    return e;
  endfunction

  task automatic do_instr(input logic [31:0] ins, input logic [31:0] st, input string nm);
    exp_t e;
    int k, w, lat;
    logic got, pre_wen, ill_v;
    logic [14:0] ld_addr;
    logic [68:0] ld_opnd;
    logic [5:0] ex_v;
    logic [4:0] wb_v, sk_en;
    sb.push_back(model(ins, st));
    @(negedge clk);
    bus.instr = ins; bus.status_out = st; bus.instr_valid = 1'b1;
    w = 0;
    while (!bus.instr_ready && w < 8) begin @(negedge clk); w++; end
    total++;
    if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL %s ready got=%b want=1", nm, bus.instr_ready); end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0; bus.status_out = $urandom; bus.instr = $urandom;
    k = 0; got = 1'b0; pre_wen = 1'b0; lat = 0; ill_v = 1'b0;
    ld_addr = '0; ld_opnd = '0; ex_v = '0; wb_v = '0; sk_en = '0;
    while (!got && k < 8) begin
      @(negedge clk); k++;
      if (k == 1) begin
        ld_addr = {bus.A_addr, bus.B_addr, bus.shift_addr, bus.en_A, bus.en_B, bus.en_S};
        ld_opnd = {bus.sel_B, bus.sel_A, bus.imme_data, bus.shift_op, bus.sel_shift, bus.shift_imme};
      end
      if (k == 2) ex_v = {bus.ALU_op, bus.en_status, bus.sel_A, bus.sel_B};
      if (bus.done) begin
        got = 1'b1; lat = k; ill_v = bus.illegal;
        wb_v = {bus.w_en, bus.w_addr};
        sk_en = {bus.en_A, bus.en_B, bus.en_S, bus.en_status, bus.w_en};
      end else pre_wen |= bus.w_en;
    end
    e = sb.pop_front();
    total++;
    if (lat !== (e.skip ? 1 : 3)) begin bad++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, e.skip ? 1 : 3); end
    total++;
    if (ill_v !== e.ill) begin bad++; $display("FAIL %s illegal got=%b want=%b", nm, ill_v, e.ill); end
    total++;
    if (pre_wen !== 1'b0) begin bad++; $display("FAIL %s early_wen got=%b want=0", nm, pre_wen); end
    if (e.skip) begin
      total++;
      if (sk_en !== 5'b0) begin bad++; $display("FAIL %s skip_en got=%b want=00000", nm, sk_en); end
    end else begin
      total++;
      if (ld_addr !== {e.a, e.b, e.s, 3'b111}) begin bad++; $display("FAIL %s load_addr got=%h want=%h", nm, ld_addr, {e.a, e.b, e.s, 3'b111}); end
      total++;
      if (ld_opnd !== {e.selb, e.sela, e.imm, e.sop, e.ssel, e.simm}) begin bad++; $display("FAIL %s load_operand got=%h want=%h", nm, ld_opnd, {e.selb, e.sela, e.imm, e.sop, e.ssel, e.simm}); end
      total++;
      if (ex_v !== {e.alu, e.ens, e.sela, e.selb}) begin bad++; $display("FAIL %s exec got=%b want=%b", nm, ex_v, {e.alu, e.ens, e.sela, e.selb}); end
      total++;
      if (wb_v !== {e.wen, e.wa}) begin bad++; $display("FAIL %s writeback got=%b want=%b", nm, wb_v, {e.wen, e.wa}); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.instr_ready, outs} !== {1'b1, 95'h0}) begin bad++; $display("FAIL reset_hold got=%h want=%h", {bus.instr_ready, outs}, {1'b1, 95'h0}); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.instr_ready, outs} !== {1'b1, 95'h0}) begin bad++; $display("FAIL reset_after got=%h want=%h", {bus.instr_ready, outs}, {1'b1, 95'h0}); end
  endtask

  task automatic test_add();
    do_instr(32'hE2821005, 32'h0, "add_imm");
  endtask

  task automatic test_subs();
    do_instr(32'hE0543005, 32'h0, "subs_reg");
  endtask

  task automatic test_cmp();
    do_instr(32'hE3510000, 32'h0, "cmp_imm");
  endtask

  task automatic test_moveq();
    do_instr(32'h03A004FF, 32'h0, "moveq_z0");
    do_instr(32'h03A004FF, 32'h4000_0000, "moveq_z1");
  endtask

  task automatic test_illegal();
    do_instr(32'hE0621003, 32'h0, "illegal_op3");
  endtask

  task automatic test_conds();
    logic [3:0] cc;
    for (int c = 0; c < 16; c++) begin
      cc = 4'(c);
      for (int r = 0; r < 3; r++) do_instr({cc, 28'h2821005}, {4'($urandom_range(0, 15)), 28'h0}, "cond");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] lst [4];
    exp_t e;
    int i, cyc, last, nd;
    logic pend;
    lst = '{32'hE1932514, 32'hE2276F3F, 32'hE0198FCA, 32'hE3A07003};
    i = 0; cyc = 0; last = -1; nd = 0;
    @(negedge clk);
    bus.status_out = 32'h0; bus.instr = lst[0]; bus.instr_valid = 1'b1;
    sb.push_back(model(lst[0], 32'h0));
    while (nd < 4 && cyc < 40) begin
      pend = bus.instr_ready && bus.instr_valid;
      @(posedge clk); #1;
      if (pend) begin
        i++;
        if (i < 4) begin bus.instr = lst[i]; sb.push_back(model(lst[i], 32'h0)); end
        else bus.instr_valid = 1'b0;
      end
      @(negedge clk); cyc++;
      if (bus.done) begin
        e = sb.pop_front();
        total++;
        if ({bus.illegal, bus.w_en, bus.w_addr} !== {e.ill, e.wen, e.wa}) begin bad++; $display("FAIL b2b_wb%0d got=%b want=%b", nd, {bus.illegal, bus.w_en, bus.w_addr}, {e.ill, e.wen, e.wa}); end
        if (last >= 0) begin
          total++;
          if (cyc - last !== 4) begin bad++; $display("FAIL b2b_spacing%0d got=%0d want=4", nd, cyc - last); end
        end
        last = cyc; nd++;
      end
    end
    bus.instr_valid = 1'b0;
    total++;
    if (nd !== 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", nd); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    bus.instr = 32'hE0543005; bus.status_out = 32'h0; bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.ALU_op, bus.en_status} !== {3'b001, 1'b1}) begin bad++; $display("FAIL mid_exec got=%b want=0011", {bus.ALU_op, bus.en_status}); end
    rst = 1'b1; #1;
    total++;
    if (outs !== 95'h0) begin bad++; $display("FAIL mid_rst_outs got=%h want=0", outs); end
    @(negedge clk);
    total++;
    if ({bus.instr_ready, outs} !== {1'b1, 95'h0}) begin bad++; $display("FAIL mid_rst_idle got=%h want=%h", {bus.instr_ready, outs}, {1'b1, 95'h0}); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= bus.w_en | bus.done; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_quiet got=%b want=0", seen); end
    total++;
    if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", bus.instr_ready); end
  endtask

  initial begin
    bus.instr = 32'h0; bus.instr_valid = 1'b0; bus.status_out = 32'h0;
    test_reset();
    test_add();
    test_subs();
    test_cmp();
    test_moveq();
    test_illegal();
    test_conds();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dp_controller.md
DP_CONTROLLER -- requirements
Module: dp_controller

Interface
REQ-001 The block SHALL have these ports: clk, in, 1, system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have these ports: rst, in, 1, synchronous active-high reset.
REQ-003 The block SHALL have these ports: instr, in, 32, ARM data-processing instruction, qualified by instr_valid.
REQ-004 The block SHALL have these ports: instr_valid, in, 1, instruction offered; instr_ready, out, 1, the block can accept an instruction.
REQ-005 The block SHALL have these ports: status_out, in, 32, datapath flags with N=bit31, Z=bit30, C=bit29, V=bit28.
REQ-006 The block SHALL have these ports: A_addr, B_addr, shift_addr, out, 4 each, register-file read addresses.
REQ-007 The block SHALL have these ports: en_A, en_B, en_S, en_status, out, 1 each, datapath register enables.
REQ-008 The block SHALL have these ports: shift_op, out, 2; shift_imme, out, 32; sel_shift, sel_A, sel_B, out, 1 each; imme_data, out, 32; ALU_op, out, 3.
REQ-009 The block SHALL have these ports: w_en, out, 1; w_addr, out, 4; register-file writeback.
REQ-010 The block SHALL have these ports: done, out, 1, one-cycle retire pulse; illegal, out, 1, one-cycle undefined-opcode pulse.

Function
REQ-011 States SHALL be IDLE, LOAD, EXEC, WB and SKIP, and the block SHALL assert instr_ready only in IDLE.
REQ-012 An accept SHALL occur on a cycle in which instr_valid and instr_ready are both high, and the block SHALL latch instr into an internal register on that cycle.
REQ-013 On accept, the block SHALL evaluate the condition field instr[31:28] (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL) against status_out sampled in the same cycle.
REQ-014 Condition 1111 SHALL be treated as a failed condition.
REQ-015 If the condition fails, the next state SHALL be SKIP; otherwise the next state SHALL be LOAD.
REQ-016 Supported opcodes instr[24:21] SHALL be: AND 0000 (ALU_op 010), EOR 0001 (100), SUB 0010 (001), ADD 0100 (000), CMP 1010 (001), ORR 1100 (011), MOV 1101 (000 with sel_A=1).
REQ-017 Any other opcode SHALL go to SKIP and pulse illegal together with done.
REQ-018 In LOAD, the block SHALL drive A_addr=Rn (instr[19:16]), B_addr=Rm (instr[3:0]) and shift_addr=Rs (instr[11:8]), and SHALL assert en_A, en_B and en_S.
REQ-019 Immediate form (instr[25]=1): the block SHALL set sel_B=1 and imme_data = zero-extended instr[7:0] rotated right by 2*instr[11:8].
REQ-020 Register form: the block SHALL set sel_B=0 and shift_op=instr[6:5].
REQ-021 Register form with instr[4]=0: the block SHALL set sel_shift=0 and shift_imme=zero-extended instr[11:7].
REQ-022 Register form with instr[4]=1: the block SHALL set sel_shift=1.
REQ-023 In EXEC, the block SHALL hold ALU_op, sel_A and sel_B, and SHALL assert en_status iff S=instr[20]=1, or unconditionally for CMP.
REQ-024 In WB, the block SHALL assert w_en with w_addr=Rd (instr[15:12]), except for CMP, which SHALL assert no w_en.
REQ-025 Every WB and SKIP cycle SHALL pulse done, and the next state SHALL be IDLE.
REQ-026 Latency SHALL be: executed instruction accept to done = 3 cycles; skipped or illegal instruction accept to done = 1 cycle.
REQ-027 Throughput SHALL be one executed instruction per 4 cycles.
REQ-028 All datapath control outputs SHALL be combinational from the state and the latched instruction, and SHALL be 0 outside their stated state.
REQ-029 instr_valid high while instr_ready is low SHALL be ignored; the offering party holds instr stable until accept.

Reset
REQ-030 rst high at any clock edge SHALL force IDLE and clear the latched instruction, even mid-sequence, with no w_en, en_* or done in the following cycle.
REQ-031 During and after reset, every output SHALL be 0 except instr_ready, which SHALL be 1 once the block is in IDLE.

Structure
REQ-032 A shared package SHALL hold the state enum, the ALU_op encodings, the ARM opcode and condition constants, and the status bit indices.
REQ-033 Condition evaluation SHALL be a separate combinational sub-module, cond_check (cond[3:0], flags[3:0] -> pass).

Verification
REQ-034 Scenario: ADD r1,r2,#5 (0xE2821005) -> LOAD with A_addr=2, sel_B=1, imme_data=5; EXEC with ALU_op=000 and en_status=0; WB with w_en=1 and w_addr=1; done on cycle 3.
REQ-035 Scenario: SUBS r3,r4,r5 (0xE0543005) -> sel_shift=0, shift_imme=0, ALU_op=001, en_status=1 in EXEC, w_addr=3.
REQ-036 Scenario: CMP r1,#0 (0xE3510000) -> en_status=1 in EXEC and no w_en in WB.
REQ-037 Scenario: MOVEQ r0,#0xFF000000 (0x03A004FF) with Z=0 -> SKIP, done on cycle 1, no enables asserted; repeated with Z=1 -> imme_data=0xFF000000, sel_A=1, w_addr=0.
REQ-038 Scenario: 0xE0621003 (opcode 0011) -> illegal=1 and done=1 one cycle after accept, with no writes.
REQ-039 Scenario: rst asserted during EXEC -> next cycle IDLE, w_en never asserts, instr_ready=1.
